time_counter: RTL and testbench
===============================

Name: time_counter

Overview:
- Timekeeping core of the clock.
- Divides the system clock to a 1 Hz tick and keeps hours/minutes/seconds as registered 7-bit binary values.
- Each 7-bit value drives one two-digit seven-segment decoder stage directly downstream.
- Includes a button-driven set-mode state machine for adjusting hours and minutes.

Parameters:
- CLK_FREQ, 50_000_000: system clock cycles per second. Prescaler terminal count is CLK_FREQ-1. Minimum 2.
- PRE_W, 26: prescaler counter width. Must satisfy 2^PRE_W > CLK_FREQ-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_mode  input  1  mode button. Level, already synchronised and debounced. Internally rising-edge detected.
- btn_inc  input  1  increment button. Level, synchronised and debounced. Internally rising-edge detected.
- sec  output  7  seconds, binary 0-59.
- min  output  7  minutes, binary 0-59.
- hour  output  7  hours, binary 0-23.
- mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN.
- tick_1hz  output  1  one-cycle pulse when the prescaler reaches terminal count in RUN.
- day_pulse  output  1  one-cycle pulse on rollover from 23:59:59 to 00:00:00.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, mode=RUN, prescaler 0, button edge registers 0.
  - Reset mid-count or mid-set drops immediately to these values.
  - The first tick comes CLK_FREQ cycles after reset deasserts.
- Edge detect: a button event is prev=0 and cur=1. Holding a button produces exactly one event.
- Prescaler: counts 0..CLK_FREQ-1 in RUN only.
  - At terminal count it wraps to 0 and asserts tick_1hz for that cycle.
  - In SET_HOUR and SET_MIN it is held at 0.
- Counter update (RUN): the cycle after tick_1hz, sec increments.
  - sec 59 wraps to 0 and carries to min, in the same cycle.
  - min 59 wraps to 0 and carries to hour.
  - hour 23 wraps to 0.
  - The full 23:59:59 rollover reaches 00:00:00 in one update cycle. day_pulse is asserted in that same cycle.
  - Outputs are always registered and never exceed their limits.
- FSM transitions on a btn_mode event: RUN->SET_HOUR, SET_HOUR->SET_MIN, SET_MIN->RUN.
  - Entering SET_HOUR clears sec to 0.
  - On leaving SET_MIN, counting restarts with the prescaler at 0.
- btn_inc event:
  - In SET_HOUR: hour+1, 23 wraps to 0, no carry.
  - In SET_MIN: min+1, 59 wraps to 0, no carry into hour.
  - In RUN: ignored.
- Simultaneous btn_mode and btn_inc events: mode wins and the inc is dropped.
- A tick coinciding with a RUN->SET_HOUR transition is discarded. sec=0 regardless.
- No tick_1hz or day_pulse is asserted outside RUN.

Optional Feature:
- Macro: TIME_COUNTER_HOUR12_EN.
- Defined:
  - hour output ranges 1-12.
  - An extra port pm (output, 1 bit) is added, reset value 0.
  - Reset hour is 12 with pm=0 (12 AM).
  - Run rollover: 11:59:59 -> 12:00:00 toggles pm; 12:59:59 -> 01:00:00 leaves pm unchanged.
  - day_pulse fires on the transition to 12:00:00 with pm=0.
  - SET_HOUR increments through 12 AM, 1 AM ... 11 PM.
- Undefined: 24-hour behaviour as above, no pm port.

Decomposition:
- Package clock_pkg holds:
  - mode encoding constants MODE_RUN=2'd0, MODE_SET_HOUR=2'd1, MODE_SET_MIN=2'd2;
  - limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, HOUR12_MAX=12;
  - width constant TIME_W=7.
- One sub-module, tick_gen:
  - prescaler with enable and synchronous clear;
  - outputs the tick pulse;
  - parameterised by CLK_FREQ and PRE_W.
- Edge detection and the FSM stay in time_counter.

Test Plan:
- CLK_FREQ=4. Release reset and run 40 cycles -> tick_1hz on cycles 4, 8, ... and sec=10 at the end; min=0, hour=0.
- Force state 23:59:58 via the set path, then run 2 ticks -> 23:59:59 then 00:00:00, with day_pulse high exactly one cycle coincident with the wrap.
- btn_mode pulse, then 25 btn_inc pulses -> mode=1, hour=1 (wrapped after 23). Next btn_mode with 60 btn_inc -> mode=2, min=0 and hour unchanged.
- btn_mode and btn_inc rise in the same cycle while in RUN -> mode=1, hour unchanged. btn_inc held high 20 cycles -> exactly one increment.
- Assert rst asynchronously mid-SET_MIN (between clock edges) -> all outputs 0 and mode=0 before the next clk edge. First tick_1hz 4 cycles after release.
- With TIME_COUNTER_HOUR12_EN: reset -> hour=12, pm=0. Set 11:59:59 and run 1 tick -> 12:00:00 with pm=1. Set 12:59:59 and run 1 tick -> 01:00:00 with pm unchanged.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and small helpers for the time_counter clock core.
// Holds the mode encoding, the time-field limits and the wrap/12-hour increment functions.
package clock_pkg;

    localparam int TIME_W = 7;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;

    localparam logic [TIME_W-1:0] SEC_MAX    = 7'd59;
    localparam logic [TIME_W-1:0] MIN_MAX    = 7'd59;
    localparam logic [TIME_W-1:0] HOUR_MAX   = 7'd23;
    localparam logic [TIME_W-1:0] HOUR12_MAX = 7'd12;
    localparam logic [TIME_W-1:0] HOUR12_PRE = HOUR12_MAX - 7'd1;

    // Increment with wrap to zero; anything at or above the limit also wraps.
    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max_v);
        return (v >= max_v) ? '0 : v + 1'b1;
    endfunction

    // 12-hour step returning {pm, hour}: 11 -> 12 flips the meridiem, 12 -> 1 keeps it.
    function automatic logic [TIME_W:0] hour12_inc(input logic [TIME_W-1:0] h,
                                                   input logic             p);
        if (h >= HOUR12_MAX)
            return {p, 7'd1};
        else if (h == HOUR12_PRE)
            return {~p, HOUR12_MAX};
        else
            return {p, h + 7'd1};
    endfunction

endpackage

// File: rtl/time_counter_tick_gen.sv
// Prescaler dividing the system clock down to a one-cycle tick every CLK_FREQ cycles.
// Counts only while enabled; synchronous clear has priority over counting.
module tick_gen #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int PRE_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PRE_W-1:0] TC = PRE_W'(CLK_FREQ - 1);

    logic [PRE_W-1:0] count;

    assign tick = en & (count == TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= (count == TC) ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/time_counter.sv
// Timekeeping core: 1 Hz seconds/minutes/hours counters with a button-driven set mode.
// Define TIME_COUNTER_HOUR12_EN for 12-hour display with an added pm output.
module time_counter
    import clock_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int PRE_W    = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [TIME_W-1:0] sec,
    output logic [TIME_W-1:0] min,
    output logic [TIME_W-1:0] hour,
    output logic [1:0]        mode,
    output logic              tick_1hz,
`ifdef TIME_COUNTER_HOUR12_EN
    output logic              pm,
`endif
    output logic              day_pulse
);

`ifdef TIME_COUNTER_HOUR12_EN
    localparam logic [TIME_W-1:0] HOUR_RST = HOUR12_MAX;
`else
    localparam logic [TIME_W-1:0] HOUR_RST = '0;
`endif

    logic              mode_prev, inc_prev;
    logic              mode_ev, inc_ev;
    logic              run, tick, advance;
    logic              sec_wrap, min_wrap;
    logic              min_step, hour_step, day_roll;
    logic [TIME_W-1:0] hour_inc;

    assign mode_ev = btn_mode & ~mode_prev;
    assign inc_ev  = btn_inc & ~inc_prev;
    assign run     = (mode == MODE_RUN);

    // Any mode change restarts the prescaler, so a tick racing RUN->SET_HOUR is lost.
    tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .PRE_W    (PRE_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (mode_ev),
        .tick (tick)
    );

    assign tick_1hz = tick;
    assign advance  = tick & ~mode_ev;
    assign sec_wrap = (sec >= SEC_MAX);
    assign min_wrap = (min >= MIN_MAX);

    // A mode event swallows a same-cycle inc event.
    assign min_step  = (advance & sec_wrap)
                     | (inc_ev & ~mode_ev & (mode == MODE_SET_MIN));
    assign hour_step = (advance & sec_wrap & min_wrap)
                     | (inc_ev & ~mode_ev & (mode == MODE_SET_HOUR));

`ifdef TIME_COUNTER_HOUR12_EN
    logic pm_inc;
    assign {pm_inc, hour_inc} = hour12_inc(hour, pm);
    assign day_roll = advance & sec_wrap & min_wrap & pm & (hour == HOUR12_PRE);
`else
    assign hour_inc = wrap_inc(hour, HOUR_MAX);
    assign day_roll = advance & sec_wrap & min_wrap & (hour >= HOUR_MAX);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
            mode      <= MODE_RUN;
            sec       <= '0;
            min       <= '0;
            hour      <= HOUR_RST;
            day_pulse <= 1'b0;
`ifdef TIME_COUNTER_HOUR12_EN
            pm        <= 1'b0;
`endif
        end else begin
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
            day_pulse <= day_roll;

            if (mode_ev) begin
                case (mode)
                    MODE_RUN:      mode <= MODE_SET_HOUR;
                    MODE_SET_HOUR: mode <= MODE_SET_MIN;
                    default:       mode <= MODE_RUN;
                endcase
            end

            if (mode_ev && run)
                sec <= '0;
            else if (advance)
                sec <= wrap_inc(sec, SEC_MAX);

            if (min_step)
                min <= wrap_inc(min, MIN_MAX);

            if (hour_step) begin
                hour <= hour_inc;
`ifdef TIME_COUNTER_HOUR12_EN
                pm   <= pm_inc;
`endif
            end
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter with a seconds-of-day reference model.
// Honours TIME_COUNTER_HOUR12_EN by mapping the model's 24-hour time onto the 12-hour outputs.
module tb_time_counter;

    localparam int CF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [6:0] sec, min_o, hour;
    logic [1:0] mode;
    logic       tick_1hz, day_pulse;
`ifdef TIME_COUNTER_HOUR12_EN
    logic       pm;
`endif

    int checks = 0;
    int fails  = 0;

    // Reference state: time of day in seconds, prescaler phase, mode, button history.
    int m_tod = 0, m_pre = 0, m_mode = 0;
    bit m_mprev = 0, m_iprev = 0, m_day = 0;

    time_counter #(
        .CLK_FREQ (CF),
        .PRE_W    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec       (sec),
        .min       (min_o),
        .hour      (hour),
        .mode      (mode),
        .tick_1hz  (tick_1hz),
`ifdef TIME_COUNTER_HOUR12_EN
        .pm        (pm),
`endif
        .day_pulse (day_pulse)
    );

    always #5 clk = ~clk;

    function automatic int hr(input int h24);
`ifdef TIME_COUNTER_HOUR12_EN
        return (h24 % 12 == 0) ? 12 : h24 % 12;
`else
        return h24;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tod <= 0; m_pre <= 0; m_mode <= 0;
            m_mprev <= 0; m_iprev <= 0; m_day <= 0;
        end else begin : step
            int tod, pre, md, hh, mm, ss;
            bit mev, iev, day;
            tod = m_tod; pre = m_pre; md = m_mode; day = 0;
            hh = tod / 3600; mm = (tod / 60) % 60; ss = tod % 60;
            mev = btn_mode && !m_mprev;
            iev = btn_inc && !m_iprev;
            if (mev) begin
                pre = 0;
                if (md == 0) begin
                    md = 1;
                    tod = tod - ss;
                end else if (md == 1) md = 2;
                else md = 0;
            end else if (md == 0) begin
                if (pre == CF - 1) begin
                    pre = 0;
                    tod = tod + 1;
                    if (tod == 86400) begin
                        tod = 0;
                        day = 1;
                    end
                end else pre = pre + 1;
            end else if (iev) begin
                if (md == 1) tod = ((hh + 1) % 24) * 3600 + mm * 60 + ss;
                else tod = hh * 3600 + ((mm + 1) % 60) * 60 + ss;
            end
            m_tod <= tod; m_pre <= pre; m_mode <= md; m_day <= day;
            m_mprev <= btn_mode; m_iprev <= btn_inc;
        end
    end

    // Every clocked cycle out of reset, all outputs must match the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("sec", int'(sec), m_tod % 60);
            chk("min", int'(min_o), (m_tod / 60) % 60);
            chk("hour", int'(hour), hr(m_tod / 3600));
            chk("mode", int'(mode), m_mode);
            chk("tick_1hz", int'(tick_1hz), int'(m_mode == 0 && m_pre == CF - 1));
            chk("day_pulse", int'(day_pulse), int'(m_day));
`ifdef TIME_COUNTER_HOUR12_EN
            chk("pm", int'(pm), int'(m_tod >= 43200));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; cyc(1);
        btn_mode = 1'b0; cyc(1);
    endtask

    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) begin
            btn_inc = 1'b1; cyc(1);
            btn_inc = 1'b0; cyc(1);
        end
    endtask

    initial begin
        int nt, first;
        cyc(3);
        rst = 1'b0;

        chk("rst_sec", int'(sec), 0);
        chk("rst_min", int'(min_o), 0);
        chk("rst_hour", int'(hour), hr(0));
        chk("rst_mode", int'(mode), 0);
`ifdef TIME_COUNTER_HOUR12_EN
        chk("rst_pm", int'(pm), 0);
`endif

        nt = 0; first = 0;
        for (int i = 1; i <= 40; i++) begin
            if (tick_1hz) begin
                nt++;
                if (first == 0) first = i;
            end
            cyc(1);
        end
        chk("ticks_in_40", nt, 10);
        chk("first_tick_cycle", first, 4);
        chk("sec_after_40", int'(sec), 10);

        press_mode();
        chk("set_hour_mode", int'(mode), 1);
        chk("set_hour_sec_clr", int'(sec), 0);
        press_inc(25);
        chk("hour_after_25", int'(hour), hr(1));
        press_mode();
        chk("set_min_mode", int'(mode), 2);
        press_inc(60);
        chk("min_after_60", int'(min_o), 0);
        chk("hour_kept", int'(hour), hr(1));

        press_mode();
        press_mode();
        press_inc(22);
        press_mode();
        press_inc(59);
        press_mode();
        chk("run_again", int'(mode), 0);
        cyc(231);
        chk("t58_sec", int'(sec), 58);
        chk("t58_min", int'(min_o), 59);
        chk("t58_hour", int'(hour), hr(23));
        cyc(4);
        chk("t59_sec", int'(sec), 59);
        cyc(3);
        chk("pre_wrap_day", int'(day_pulse), 0);
        cyc(1);
        chk("wrap_day", int'(day_pulse), 1);
        chk("wrap_sec", int'(sec), 0);
        chk("wrap_min", int'(min_o), 0);
        chk("wrap_hour", int'(hour), hr(0));
        cyc(1);
        chk("post_wrap_day", int'(day_pulse), 0);

        btn_mode = 1'b1; btn_inc = 1'b1; cyc(1);
        btn_mode = 1'b0; btn_inc = 1'b0; cyc(1);
        chk("simul_mode", int'(mode), 1);
        chk("simul_hour", int'(hour), hr(0));
        btn_inc = 1'b1; cyc(20);
        btn_inc = 1'b0; cyc(1);
        chk("held_inc_hour", int'(hour), hr(1));

        press_mode();
        press_inc(2);
        chk("mid_set_min", int'(min_o), 2);
        #3;
        rst = 1'b1;
        #1;
        chk("async_sec", int'(sec), 0);
        chk("async_min", int'(min_o), 0);
        chk("async_hour", int'(hour), hr(0));
        chk("async_mode", int'(mode), 0);
        cyc(1);
        rst = 1'b0;
        first = 0;
        for (int i = 1; i <= 4; i++) begin
            if (tick_1hz && first == 0) first = i;
            cyc(1);
        end
        chk("first_tick_after_rst", first, 4);

        for (int i = 0; i < 3000; i++) begin
            btn_mode = ($urandom_range(0, 39) == 0);
            btn_inc  = ($urandom_range(0, 3) == 0);
            cyc(1);
        end
        btn_mode = 1'b0; btn_inc = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
